// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the SparrowRV trap sequencer: CSR addresses, mcause codes,
// FSM state encoding and the arbiter result payload.
package trap_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CSR_AW = 12;
    localparam int unsigned ST_W   = 3;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MTVAL   = 12'h343;

    localparam logic [XLEN-1:0] MCAUSE_ILLEGAL = 32'd2;
    localparam logic [XLEN-1:0] MCAUSE_EBREAK  = 32'd3;
    localparam logic [XLEN-1:0] MCAUSE_ECALL   = 32'd11;
    localparam logic [XLEN-1:0] MCAUSE_EXT     = 32'h8000_000B;
    localparam logic [XLEN-1:0] MCAUSE_SOFT    = 32'h8000_0003;
    localparam logic [XLEN-1:0] MCAUSE_TMR     = 32'h8000_0007;

    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;

    localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [ST_W-1:0] ST_T_MEPC    = 3'd1;
    localparam logic [ST_W-1:0] ST_T_MCAUSE  = 3'd2;
    localparam logic [ST_W-1:0] ST_T_MTVAL   = 3'd3;
    localparam logic [ST_W-1:0] ST_T_MSTATUS = 3'd4;
    localparam logic [ST_W-1:0] ST_T_JUMP    = 3'd5;
    localparam logic [ST_W-1:0] ST_R_MSTATUS = 3'd6;
    localparam logic [ST_W-1:0] ST_R_JUMP    = 3'd7;

    typedef struct packed {
        logic            valid;
        logic            is_irq;
        logic            is_mret;
        logic [XLEN-1:0] cause;
    } arb_res_t;

endpackage

// File: rtl/trap_ctrl_if.sv
// Trap channel between the trap sequencer and the CSR file
// (combinational read, synchronous write).
interface trap_ctrl_if;

    logic                                trap_csr_we_o;
    logic [trap_ctrl_pkg::CSR_AW-1:0]    trap_csr_addr_o;
    logic [trap_ctrl_pkg::XLEN-1:0]      trap_csr_wdata_o;
    logic [trap_ctrl_pkg::XLEN-1:0]      trap_csr_rdata_i;

    modport master (
        output trap_csr_we_o,
        output trap_csr_addr_o,
        output trap_csr_wdata_o,
        input  trap_csr_rdata_i
    );

    modport slave (
        input  trap_csr_we_o,
        input  trap_csr_addr_o,
        input  trap_csr_wdata_o,
        output trap_csr_rdata_i
    );

endinterface

// File: rtl/trap_ctrl_arb.sv
// trap_arb: combinational priority encoder for exceptions, mret and masked interrupts.
module trap_arb
    import trap_ctrl_pkg::*;
(
    input  logic     illegal_i,
    input  logic     ecall_i,
    input  logic     ebreak_i,
    input  logic     mret_i,
    input  logic     ex_trap_i,
    input  logic     soft_trap_i,
    input  logic     tcmp_tarp_i,
    input  logic     mie_i,
    output arb_res_t res_c
);

    always_comb begin
        res_c       = '0;
        res_c.valid = 1'b1;
        if (illegal_i) begin
            res_c.cause = MCAUSE_ILLEGAL;
        end else if (ecall_i) begin
            res_c.cause = MCAUSE_ECALL;
        end else if (ebreak_i) begin
            res_c.cause = MCAUSE_EBREAK;
        end else if (mret_i) begin
            res_c.is_mret = 1'b1;
        end else if (mie_i && ex_trap_i) begin
            res_c.is_irq = 1'b1;
            res_c.cause  = MCAUSE_EXT;
        end else if (mie_i && soft_trap_i) begin
            res_c.is_irq = 1'b1;
            res_c.cause  = MCAUSE_SOFT;
        end else if (mie_i && tcmp_tarp_i) begin
            res_c.is_irq = 1'b1;
            res_c.cause  = MCAUSE_TMR;
        end else begin
            res_c.valid = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry/exit sequencer driving the CSR trap channel and PC redirect.
// Optional TRAP_VECTORED_EN: vectored interrupt targets when mtvec[1:0]==2'b01.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inst_valid_i,
    input  logic [XLEN-1:0]  inst_pc_i,
    input  logic [XLEN-1:0]  inst_i,
    input  logic             ecall_i,
    input  logic             ebreak_i,
    input  logic             illegal_i,
    input  logic             mret_i,
    input  logic             ex_trap_i,
    input  logic             tcmp_tarp_i,
    input  logic             soft_trap_i,
    input  logic             mstatus_MIE3_i,
    trap_ctrl_if.master      trap_csr,
    output logic             hold_o,
    output logic             jump_o,
    output logic [XLEN-1:0]  jump_addr_o
);

    logic [ST_W-1:0]   state_q, state_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]   tval_q, tval_d;
    logic              we_q, we_d;
    logic              jump_q, jump_d;
    logic [CSR_AW-1:0] addr_q, addr_d;

    logic [XLEN-1:0]   rdata;
    logic [XLEN-1:0]   wdata_c;
    logic [XLEN-1:0]   jump_addr_c;
    logic [XLEN-1:0]   trap_target_c;
    logic              hold_c;
    logic              accept_c;
    arb_res_t          arb_c;

    assign rdata = trap_csr.trap_csr_rdata_i;

    trap_arb u_arb (
        .illegal_i   (illegal_i),
        .ecall_i     (ecall_i),
        .ebreak_i    (ebreak_i),
        .mret_i      (mret_i),
        .ex_trap_i   (ex_trap_i),
        .soft_trap_i (soft_trap_i),
        .tcmp_tarp_i (tcmp_tarp_i),
        .mie_i       (mstatus_MIE3_i),
        .res_c       (arb_c)
    );

    // Reset gates acceptance so hold_o stays low while rst_n is asserted.
    assign accept_c = rst_n && (state_q == ST_IDLE) && inst_valid_i && arb_c.valid;

    always_comb begin
        trap_target_c = {rdata[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if (cause_q[XLEN-1] && (rdata[1:0] == 2'b01)) begin
            trap_target_c = {rdata[XLEN-1:2], 2'b00} + {cause_q[XLEN-3:0], 2'b00};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            tval_q  <= '0;
            we_q    <= 1'b0;
            jump_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            we_q    <= we_d;
            jump_q  <= jump_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        tval_d      = tval_q;
        we_d        = 1'b0;
        jump_d      = 1'b0;
        addr_d      = '0;
        wdata_c     = '0;
        jump_addr_c = RESET_PC;
        hold_c      = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                hold_c = accept_c;
                if (accept_c) begin
                    epc_d   = inst_pc_i;
                    cause_d = arb_c.cause;
                    tval_d  = (!arb_c.is_irq && (arb_c.cause == MCAUSE_ILLEGAL)) ? inst_i : '0;
                    state_d = arb_c.is_mret ? ST_R_MSTATUS : ST_T_MEPC;
                end
            end
            ST_T_MEPC: begin
                wdata_c = epc_q;
                state_d = ST_T_MCAUSE;
            end
            ST_T_MCAUSE: begin
                wdata_c = cause_q;
                state_d = ST_T_MTVAL;
            end
            ST_T_MTVAL: begin
                wdata_c = tval_q;
                state_d = ST_T_MSTATUS;
            end
            ST_T_MSTATUS: begin
                wdata_c           = rdata;
                wdata_c[MPIE_BIT] = rdata[MIE_BIT];
                wdata_c[MIE_BIT]  = 1'b0;
                state_d           = ST_T_JUMP;
            end
            ST_T_JUMP: begin
                jump_addr_c = trap_target_c;
                state_d     = ST_IDLE;
            end
            ST_R_MSTATUS: begin
                wdata_c           = rdata;
                wdata_c[MIE_BIT]  = rdata[MPIE_BIT];
                wdata_c[MPIE_BIT] = 1'b1;
                state_d           = ST_R_JUMP;
            end
            ST_R_JUMP: begin
                jump_addr_c = rdata;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Channel controls are registered one state ahead so they line up with state_q.
        case (state_d)
            ST_T_MEPC:    begin we_d = 1'b1; addr_d = CSR_MEPC;    end
            ST_T_MCAUSE:  begin we_d = 1'b1; addr_d = CSR_MCAUSE;  end
            ST_T_MTVAL:   begin we_d = 1'b1; addr_d = CSR_MTVAL;   end
            ST_T_MSTATUS: begin we_d = 1'b1; addr_d = CSR_MSTATUS; end
            ST_T_JUMP:    begin jump_d = 1'b1; addr_d = CSR_MTVEC; end
            ST_R_MSTATUS: begin we_d = 1'b1; addr_d = CSR_MSTATUS; end
            ST_R_JUMP:    begin jump_d = 1'b1; addr_d = CSR_MEPC;  end
            default:      begin we_d = 1'b0; addr_d = '0;          end
        endcase
    end

    assign trap_csr.trap_csr_we_o    = we_q;
    assign trap_csr.trap_csr_addr_o  = addr_q;
    assign trap_csr.trap_csr_wdata_o = wdata_c;
    assign hold_o                    = hold_c;
    assign jump_o                    = jump_q;
    assign jump_addr_o               = jump_addr_c;

endmodule
